seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Inverse of the hex-to-7-segment encoder. Watches a multiplexed 7-seg display bus (segment lines + digit
//  selects) and reconstructs the hex value shown on each digit, flagging unknown/blank patterns.
//  Sits beside the display driver as a self-check/readback monitor; hands completed frames to the
//  CPU-side logic over a valid/ready handshake.
// PARAMETERS
//  NDIG           8  number of scanned digits (1..8)
//  STABLE_CYC     4  consecutive identical samples required before a digit is captured (>=1)
//  SEL_ACTIVE_LOW 1  1: digit selects active-low; 0: active-high
// PORTS
//  clk           in   1        system clock, rising edge
//  rst           in   1        asynchronous reset, active-high
//  seg_in        in   7        segments, active-high, bit0=a .. bit6=g (same encoding as the encoder)
//  dig_sel       in   NDIG     digit selects; bit i drives digit i (nibble i of value)
//  value         out  4*NDIG   decoded frame; digit i at [4i+3:4i]
//  blank_mask    out  NDIG     bit i=1: digit i showed all segments off (nibble reads 0)
//  err_mask      out  NDIG     bit i=1: digit i showed a pattern outside the 16-entry table (nibble reads 0)
//  value_valid   out  1        frame available on value/blank_mask/err_mask
//  value_ready   in   1        consumer accepts frame when value_valid&&value_ready at a rising edge
//  overrun       out  1        sticky: a completed frame was dropped because the previous one was unaccepted
//  clr_overrun   in   1        synchronous clear of overrun
// BEHAVIOUR
//  - Reset: value=0, blank_mask=0, err_mask=0, value_valid=0, overrun=0; internal sample regs, stability
//    counter, captured flag, seen mask and working digit regs all 0. Reset mid-frame discards partial frame.
//  - Input stage: seg_in/dig_sel registered once (s_seg, s_sel), polarity-normalised to active-high.
//  - Stability: cnt saturates at STABLE_CYC. Cleared to 1 when {s_seg,s_sel} differs from the previous
//    sample, else incremented. Non-one-hot s_sel (zero or >1 bits) holds cnt at 0: no capture.
//  - Capture: when cnt reaches STABLE_CYC with one-hot s_sel and captured flag clear -> working reg of the
//    selected digit loaded, seen[i] set, captured flag set. Flag clears on any sample change, so each dwell
//    captures once. Inputs stable from before edge k: sample at edge k, capture at edge k+STABLE_CYC-1.
//  - Decode: exact-match against the 16 encoder patterns (0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:27 8:7F
//    9:6F A:77 b:7C C:39 d:5E E:79 F:71). 00 -> blank, nibble 0. Anything else -> err, nibble 0.
//  - Re-capture of a digit already seen this frame overwrites its working reg (latest wins).
//  - States: COLLECT (seen!=all ones) -> COMPLETE (seen==all ones, one cycle) -> COLLECT.
//    In COMPLETE: seen cleared; if !value_valid or (value_valid&&value_ready) this edge -> outputs loaded
//    from working regs, value_valid=1 after the next edge; else frame dropped, overrun<=1, outputs unchanged.
//  - Handshake: outputs held stable while value_valid && !value_ready. Acceptance clears value_valid next
//    edge unless a new frame loads on the same edge (then value_valid stays 1, no overrun).
//  - overrun: set wins over simultaneous clr_overrun.
//  - Latency: last digit of a frame stable before edge k -> value_valid high after edge k+STABLE_CYC.
// TESTING
//  1 Reset: assert rst asynchronously mid-scan -> all outputs 0 immediately; no value_valid until a full
//    new frame is scanned.
//  2 NDIG=8, STABLE_CYC=4, scan digits 0..7 with patterns for 1,2,3,4,5,6,7,8, 6 cycles each, value_ready=1
//    -> value=32'h87654321, err_mask=0, blank_mask=0, one-cycle value_valid pulse.
//  3 Dwell 3 cycles on one digit (< STABLE_CYC) -> no capture, seen unchanged; no frame ever completes.
//  4 Digit 2 shows 7'h00, digit 5 shows 7'h7E -> blank_mask=8'h04, err_mask=8'h20, nibbles 2 and 5 = 0.
//  5 value_ready=0 across two completed frames -> first frame held stable, overrun=1; clr_overrun -> 0;
//    value_ready=1 -> value_valid drops next edge.
//  6 dig_sel=8'h00 (active-low: all on) glitch mid-dwell -> no capture; cnt restarts when one-hot returns.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Readback monitor for a multiplexed 7-segment bus.
// Reconstructs the hex frame shown on the scanned digits.
module seg_scan_decoder #(
  parameter int NDIG           = 8,
  parameter int STABLE_CYC     = 4,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   blank_mask,
  output logic [NDIG-1:0]   err_mask,
  output logic              value_valid,
  input  logic              value_ready,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC);

  typedef enum logic {COLLECT, COMPLETE} state_t;

  // result is {blank, err, nibble}
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 6'h00;
      7'h06:   decode = 6'h01;
      7'h5B:   decode = 6'h02;
      7'h4F:   decode = 6'h03;
      7'h66:   decode = 6'h04;
      7'h6D:   decode = 6'h05;
      7'h7D:   decode = 6'h06;
      7'h27:   decode = 6'h07;
      7'h7F:   decode = 6'h08;
      7'h6F:   decode = 6'h09;
      7'h77:   decode = 6'h0A;
      7'h7C:   decode = 6'h0B;
      7'h39:   decode = 6'h0C;
      7'h5E:   decode = 6'h0D;
      7'h79:   decode = 6'h0E;
      7'h71:   decode = 6'h0F;
      7'h00:   decode = 6'b10_0000;
      default: decode = 6'b01_0000;
    endcase
  endfunction

  logic [6:0]        s_seg;
  logic [NDIG-1:0]   s_sel;
  logic [CW-1:0]     cnt;
  logic              captured;
  logic [NDIG-1:0]   seen;
  logic [4*NDIG-1:0] wrk_val;
  logic [NDIG-1:0]   wrk_blank;
  logic [NDIG-1:0]   wrk_err;
  state_t            state;

  logic [NDIG-1:0]   sel_n;
  logic              one_hot;
  logic              changed;
  logic [CW-1:0]     cnt_n;
  logic              hold;
  logic              capture;
  logic [NDIG-1:0]   cap_bits;
  logic [5:0]        dec;
  logic [NDIG-1:0]   seen_n;
  logic              load;

  // cnt/captured describe the sample being loaded into s_seg/s_sel
  always_comb begin
    sel_n    = SEL_ACTIVE_LOW ? ~dig_sel : dig_sel;
    one_hot  = (sel_n != '0) && ((sel_n & (sel_n - NDIG'(1))) == '0);
    changed  = (seg_in != s_seg) || (sel_n != s_sel);
    cnt_n    = cnt;
    if (!one_hot)
      cnt_n = '0;
    else if (changed)
      cnt_n = CW'(1);
    else if (cnt < CMAX)
      cnt_n = cnt + CW'(1);
    hold     = captured && !changed;
    capture  = one_hot && (cnt_n == CMAX) && !hold;
    cap_bits = capture ? sel_n : '0;
    dec      = decode(seg_in);
    seen_n   = (state == COMPLETE) ? cap_bits : (seen | cap_bits);
    load     = (state == COMPLETE) && (!value_valid || value_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg       <= '0;
      s_sel       <= '0;
      cnt         <= '0;
      captured    <= 1'b0;
      seen        <= '0;
      wrk_val     <= '0;
      wrk_blank   <= '0;
      wrk_err     <= '0;
      state       <= COLLECT;
      value       <= '0;
      blank_mask  <= '0;
      err_mask    <= '0;
      value_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      s_seg    <= seg_in;
      s_sel    <= sel_n;
      cnt      <= cnt_n;
      captured <= capture | hold;
      for (int i = 0; i < NDIG; i++) begin
        if (cap_bits[i]) begin
          wrk_val[4*i +: 4] <= dec[3:0];
          wrk_blank[i]      <= dec[5];
          wrk_err[i]        <= dec[4];
        end
      end
      seen  <= seen_n;
      state <= (&seen_n) ? COMPLETE : COLLECT;
      if (load) begin
        value       <= wrk_val;
        blank_mask  <= wrk_blank;
        err_mask    <= wrk_err;
        value_valid <= 1'b1;
      end else if (value_valid && value_ready) begin
        value_valid <= 1'b0;
      end
      // a dropped frame beats a same-cycle clear
      if ((state == COMPLETE) && !load)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (NDIG=8, STABLE_CYC=4,
// active-low selects); vectors apply and sample on the falling edge.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [7:0]  dig_sel;
  logic [31:0] value;
  logic [7:0]  blank_mask;
  logic [7:0]  err_mask;
  logic        value_valid;
  logic        value_ready;
  logic        overrun;
  logic        clr_overrun;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int v0;
  logic [55:0] pats;

  seg_scan_decoder #(
    .NDIG(8),
    .STABLE_CYC(4),
    .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .dig_sel(dig_sel),
    .value(value),
    .blank_mask(blank_mask),
    .err_mask(err_mask),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (value_valid === 1'b1) vcount++;

  function automatic logic [6:0] enc(input int n);
    case (n)
      0: enc = 7'h3F;  1: enc = 7'h06;  2: enc = 7'h5B;  3: enc = 7'h4F;
      4: enc = 7'h66;  5: enc = 7'h6D;  6: enc = 7'h7D;  7: enc = 7'h27;
      8: enc = 7'h7F;  9: enc = 7'h6F; 10: enc = 7'h77; 11: enc = 7'h7C;
     12: enc = 7'h39; 13: enc = 7'h5E; 14: enc = 7'h79; 15: enc = 7'h71;
      default: enc = 7'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic show(input int d, input logic [6:0] p, input int n);
    seg_in  = p;
    dig_sel = ~(8'd1 << d);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [55:0] p, input int last);
    for (int d = 0; d < 8; d++)
      show(d, p[7*d +: 7], (d == 7) ? last : 6);
  endtask

  initial begin
    rst         = 1'b1;
    seg_in      = 7'h00;
    dig_sel     = 8'hFF;
    value_ready = 1'b1;
    clr_overrun = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_value", value, 32'h0);
    chk("rst_blank", 32'(blank_mask), 32'h0);
    chk("rst_err", 32'(err_mask), 32'h0);
    chk("rst_valid", 32'(value_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // basic frame 1..8 with latency and single-cycle pulse
    for (int d = 0; d < 8; d++) pats[7*d +: 7] = enc(d + 1);
    v0 = vcount;
    scan(pats, 4);
    chk("lat_early", 32'(value_valid), 32'h0);
    show(7, enc(8), 1);
    chk("f1_valid", 32'(value_valid), 32'h1);
    chk("f1_value", value, 32'h87654321);
    chk("f1_blank", 32'(blank_mask), 32'h0);
    chk("f1_err", 32'(err_mask), 32'h0);
    show(7, enc(8), 1);
    chk("f1_drop", 32'(value_valid), 32'h0);
    chk("f1_pulse", 32'(vcount - v0), 32'h1);

    // async reset in the middle of a scan
    for (int d = 0; d < 4; d++) show(d, enc(15), 6);
    show(4, enc(9), 2);
    #3 rst = 1'b1;
    #1;
    chk("arst_value", value, 32'h0);
    chk("arst_valid", 32'(value_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // partial frame after reset, short dwell, overwrite of digit 0
    v0 = vcount;
    for (int d = 4; d < 8; d++) show(d, enc(d), 6);
    show(1, enc(1), 6);
    show(2, enc(2), 6);
    show(0, enc(9), 6);
    show(3, enc(3), 3);
    show(0, enc(0), 6);
    chk("short_valid", 32'(value_valid), 32'h0);
    chk("short_count", 32'(vcount - v0), 32'h0);
    show(3, enc(3), 5);
    chk("f2_valid", 32'(value_valid), 32'h1);
    chk("f2_value", value, 32'h76543210);
    show(3, enc(3), 1);

    // blank and unknown patterns
    pats = {7'h71, 7'h79, 7'h7E, 7'h5E, 7'h39, 7'h00, 7'h7C, 7'h77};
    scan(pats, 5);
    chk("f3_valid", 32'(value_valid), 32'h1);
    chk("f3_value", value, 32'hFE0DC0BA);
    chk("f3_blank", 32'(blank_mask), 32'h04);
    chk("f3_err", 32'(err_mask), 32'h20);
    show(7, 7'h71, 1);

    // back-pressure, overrun, clear, release
    value_ready = 1'b0;
    for (int d = 0; d < 8; d++) pats[7*d +: 7] = enc(d + 1);
    scan(pats, 5);
    chk("bp_valid", 32'(value_valid), 32'h1);
    chk("bp_value", value, 32'h87654321);
    chk("bp_ovr0", 32'(overrun), 32'h0);
    for (int d = 0; d < 8; d++) pats[7*d +: 7] = enc(d + 8);
    scan(pats, 5);
    chk("ovr_set", 32'(overrun), 32'h1);
    chk("ovr_valid", 32'(value_valid), 32'h1);
    chk("ovr_hold", value, 32'h87654321);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'h0);
    chk("clr_valid", 32'(value_valid), 32'h1);
    value_ready = 1'b1;
    @(negedge clk);
    chk("acc_drop", 32'(value_valid), 32'h0);
    chk("acc_value", value, 32'h87654321);

    // all-on select glitch restarts the dwell
    for (int d = 0; d < 7; d++) show(d, enc(15 - d), 6);
    show(7, enc(8), 2);
    dig_sel = 8'h00;
    @(negedge clk);
    show(7, enc(8), 3);
    chk("gl_early3", 32'(value_valid), 32'h0);
    show(7, enc(8), 1);
    chk("gl_early4", 32'(value_valid), 32'h0);
    show(7, enc(8), 1);
    chk("gl_valid", 32'(value_valid), 32'h1);
    chk("gl_value", value, 32'h89ABCDEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
